// File: rtl/float_pkg.sv
// Shared float-format helpers: field positions, exponent bias and all-ones exponent.
// Reused by the float adder/multiplier chain and by float_to_fixed.
package float_pkg;

    localparam int unsigned MANT_LSB = 0;

    function automatic int unsigned exp_lsb(input int unsigned mant_size);
        return mant_size;
    endfunction

    function automatic int unsigned sign_pos(input int unsigned mant_size, input int unsigned exp_size);
        return mant_size + exp_size;
    endfunction

    function automatic int unsigned exp_bias(input int unsigned exp_size);
        return (32'd1 << (exp_size - 1)) - 32'd1;
    endfunction

    function automatic int unsigned exp_all_ones(input int unsigned exp_size);
        return (32'd1 << exp_size) - 32'd1;
    endfunction

endpackage

// File: rtl/float_to_fixed_if.sv
// Stream bus for float_to_fixed: float input side (s_*) and fixed-point output side (m_*).
interface float_to_fixed_if #(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned INT_SIZE      = 32
);
    logic                                 s_valid;
    logic                                 s_ready;
    logic [EXPONENT_SIZE+MANTISSA_SIZE:0] s_float;
    logic                                 m_valid;
    logic                                 m_ready;
    logic [INT_SIZE-1:0]                  m_fixed;
    logic                                 m_overflow;

    modport slave (
        input  s_valid, s_float, m_ready,
        output s_ready, m_valid, m_fixed, m_overflow
    );

    modport master (
        output s_valid, s_float, m_ready,
        input  s_ready, m_valid, m_fixed, m_overflow
    );
endinterface

// File: rtl/float_to_fixed_unpack.sv
// Combinational float field split: sign, exponent, mantissa with hidden one,
// zero (denormals flushed) and special (inf/NaN) detection.
module float_unpack
    import float_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] float_i,
    output logic                                 sign_c,
    output logic [EXPONENT_SIZE-1:0]             exp_c,
    output logic [MANTISSA_SIZE:0]               mant_c,
    output logic                                 zero_c,
    output logic                                 special_c
);
    localparam int unsigned EXP_LSB  = exp_lsb(MANTISSA_SIZE);
    localparam int unsigned SIGN_POS = sign_pos(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam logic [EXPONENT_SIZE-1:0] EXP_ONES = EXPONENT_SIZE'(exp_all_ones(EXPONENT_SIZE));

    always_comb begin
        sign_c    = float_i[SIGN_POS];
        exp_c     = float_i[EXP_LSB +: EXPONENT_SIZE];
        mant_c    = {1'b1, float_i[MANT_LSB +: MANTISSA_SIZE]};
        zero_c    = (exp_c == '0);
        special_c = (exp_c == EXP_ONES);
    end
endmodule

// File: rtl/float_to_fixed.sv
// Three-stage float -> signed fixed-point converter with saturation and a shared advance enable.
// Define FLOAT_TO_FIXED_ROUND_EN to round half away from zero instead of truncating.
module float_to_fixed
    import float_pkg::*;
#(
    parameter int unsigned MANTISSA_SIZE = 23,
    parameter int unsigned EXPONENT_SIZE = 8,
    parameter int unsigned INT_SIZE      = 32,
    parameter int unsigned FRAC_SIZE     = 0
) (
    input  logic             clk,
    input  logic             resetn,
    float_to_fixed_if.slave  bus
);
    localparam int unsigned MW = MANTISSA_SIZE + 1;    // mantissa incl. hidden one
    localparam int unsigned SW = EXPONENT_SIZE + 2;    // signed shift width
    localparam int unsigned AW = INT_SIZE + 1;         // aligned magnitude
    localparam int unsigned XW = MW + INT_SIZE;        // left-shift scratch
    localparam int unsigned RW = AW + 1;               // room for rounding carry
    localparam int          SH_OFF = int'(FRAC_SIZE) - int'(MANTISSA_SIZE) - int'(exp_bias(EXPONENT_SIZE));
    localparam logic [INT_SIZE-1:0] SAT_POS = {1'b0, {(INT_SIZE-1){1'b1}}};
    localparam logic [INT_SIZE-1:0] SAT_NEG = {1'b1, {(INT_SIZE-1){1'b0}}};

    logic adv;
    logic m_valid_q;
    logic [INT_SIZE-1:0] m_fixed_q, m_fixed_d;
    logic m_ovf_q, m_ovf_d;

    // One enable moves every stage; a stalled output freezes the whole pipe.
    assign adv            = !m_valid_q || bus.m_ready;
    assign bus.s_ready    = adv;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_fixed    = m_fixed_q;
    assign bus.m_overflow = m_ovf_q;

    // Stage 1: unpack
    logic                     s1_sign_d, s1_zero_d, s1_special_d;
    logic [EXPONENT_SIZE-1:0] s1_exp_d;
    logic [MW-1:0]            s1_mant_d;
    logic [SW-1:0]            s1_shift_d;
    logic                     v1_q, s1_sign_q, s1_zero_q, s1_special_q;
    logic [MW-1:0]            s1_mant_q;
    logic [SW-1:0]            s1_shift_q;

    float_unpack #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE)
    ) u_unpack (
        .float_i   (bus.s_float),
        .sign_c    (s1_sign_d),
        .exp_c     (s1_exp_d),
        .mant_c    (s1_mant_d),
        .zero_c    (s1_zero_d),
        .special_c (s1_special_d)
    );

    assign s1_shift_d = {2'b00, s1_exp_d} + SW'(SH_OFF);

    // Stage 2: align mantissa to the fixed-point grid
    logic [SW-1:0] s1_nsh;
    logic [XW-1:0] s1_lsh;
    logic [AW-1:0] s2_mag_d, s2_mag_q;
    logic          s2_ovf_d, s2_ovf_q;
    logic          v2_q, s2_sign_q, s2_zero_q, s2_special_q;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    logic [MW:0]   s1_rsh;
    logic          s2_guard_d, s2_guard_q;
`endif

    always_comb begin
        s2_mag_d = '0;
        s2_ovf_d = 1'b0;
        s1_nsh   = -s1_shift_q;
        s1_lsh   = XW'(s1_mant_q) << s1_shift_q;
`ifdef FLOAT_TO_FIXED_ROUND_EN
        s2_guard_d = 1'b0;
        s1_rsh     = {s1_mant_q, 1'b0} >> s1_nsh;
`endif
        if (!s1_shift_q[SW-1]) begin
            if (s1_shift_q >= SW'(INT_SIZE)) begin
                s2_ovf_d = 1'b1;
            end else begin
                s2_mag_d = s1_lsh[AW-1:0];
                s2_ovf_d = |s1_lsh[XW-1:AW];
            end
        end else if (s1_nsh <= SW'(MW)) begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
            s2_mag_d   = AW'(s1_rsh[MW:1]);
            s2_guard_d = s1_rsh[0];
`else
            s2_mag_d = AW'(s1_mant_q >> s1_nsh);
`endif
        end
    end

    // Stage 3: round, range check, saturate, apply sign
    logic [RW-1:0] s3_mag;
    logic [RW-1:0] s3_lim;

    always_comb begin
`ifdef FLOAT_TO_FIXED_ROUND_EN
        s3_mag = RW'(s2_mag_q) + RW'(s2_guard_q);
`else
        s3_mag = RW'(s2_mag_q);
`endif
        s3_lim    = (RW'(1) << (INT_SIZE - 1)) - RW'(!s2_sign_q);
        m_fixed_d = '0;
        m_ovf_d   = 1'b0;
        if (s2_special_q) begin
            m_fixed_d = s2_sign_q ? SAT_NEG : SAT_POS;
            m_ovf_d   = 1'b1;
        end else if (!s2_zero_q) begin
            if (s2_ovf_q || (s3_mag > s3_lim)) begin
                m_fixed_d = s2_sign_q ? SAT_NEG : SAT_POS;
                m_ovf_d   = 1'b1;
            end else begin
                m_fixed_d = s2_sign_q ? INT_SIZE'(-s3_mag) : INT_SIZE'(s3_mag);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q         <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_zero_q    <= 1'b0;
            s1_special_q <= 1'b0;
            s1_mant_q    <= '0;
            s1_shift_q   <= '0;
            v2_q         <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_zero_q    <= 1'b0;
            s2_special_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
            s2_mag_q     <= '0;
`ifdef FLOAT_TO_FIXED_ROUND_EN
            s2_guard_q   <= 1'b0;
`endif
            m_valid_q    <= 1'b0;
            m_fixed_q    <= '0;
            m_ovf_q      <= 1'b0;
        end else if (adv) begin
            v1_q         <= bus.s_valid;
            s1_sign_q    <= s1_sign_d;
            s1_zero_q    <= s1_zero_d;
            s1_special_q <= s1_special_d;
            s1_mant_q    <= s1_mant_d;
            s1_shift_q   <= s1_shift_d;
            v2_q         <= v1_q;
            s2_sign_q    <= s1_sign_q;
            s2_zero_q    <= s1_zero_q;
            s2_special_q <= s1_special_q;
            s2_ovf_q     <= s2_ovf_d;
            s2_mag_q     <= s2_mag_d;
`ifdef FLOAT_TO_FIXED_ROUND_EN
            s2_guard_q   <= s2_guard_d;
`endif
            m_valid_q    <= v2_q;
            if (v2_q) begin
                m_fixed_q <= m_fixed_d;
                m_ovf_q   <= m_ovf_d;
            end
        end
    end
endmodule
